// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-cache requests and stalls the pipe until they complete.
// Define LSU_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES cycles with a dmem_err pulse.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid,
  input  logic        MEM_is_load,
  input  logic        MEM_is_store,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_rs2,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] MEM_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        dmem_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;

  logic        is_ld, is_st, op, legal_f3, misalign, bad;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Load wins when both load and store flags are set.
  always_comb begin
    is_ld = MEM_is_load;
    is_st = MEM_is_store & ~MEM_is_load;
    op    = MEM_valid & (is_ld | is_st);
    if (is_ld) begin
      legal_f3 = MEM_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      legal_f3 = MEM_funct3 inside {3'b000, 3'b001, 3'b010};
    end
    misalign = ((MEM_funct3[1:0] == 2'b01) & MEM_alu_out[0]) |
               ((MEM_funct3[1:0] == 2'b10) & (MEM_alu_out[1:0] != 2'b00));
    bad = ~legal_f3 | misalign;
  end

  always_comb begin
    st_wdata = '0;
    st_be    = 4'b1111;
    if (is_st) begin
      case (MEM_funct3[1:0])
        2'b00: begin
          st_wdata = {4{MEM_rs2[7:0]}};
          st_be    = 4'b0001 << MEM_alu_out[1:0];
        end
        2'b01: begin
          st_wdata = {2{MEM_rs2[15:0]}};
          st_be    = 4'b0011 << {MEM_alu_out[1], 1'b0};
        end
        default: st_wdata = MEM_rs2;
      endcase
    end
  end

  // Lane select uses the offset latched at issue, not the live pipeline address.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'b0, ld_byte};
      3'b101:  ld_value = {16'b0, ld_half};
      default: ld_value = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    mem_stall    = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CntW'(1);
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (op) begin
          if (bad) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d    = {MEM_alu_out[31:2], 2'b00};
            wdata_d   = st_wdata;
            be_d      = st_be;
            funct3_d  = MEM_funct3;
            off_d     = MEM_alu_out[1:0];
            read_d    = is_ld;
            write_d   = is_st;
            state_d   = StBusy;
            mem_stall = 1'b1;
`ifdef LSU_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      StBusy: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            rdata_d = ld_value;
          end
          state_d = StDone;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      // Instruction is still present here; stay quiet so it is not reissued.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dmem_err = err_q;
`else
  assign dmem_err = 1'b0;
`endif

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign MEM_rdata        = rdata_q;
  assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset/timeout sequences and
// randomized transactions checked against a transaction-level arithmetic model.
module tb_mem_stage_lsu;

  localparam int KIdle = 0;
  localparam int KBad  = 1;
  localparam int KGood = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_valid, MEM_is_load, MEM_is_store;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_out, MEM_rs2;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] MEM_rdata;
  logic        mem_stall, misaligned, dmem_err;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .MEM_valid        (MEM_valid),
    .MEM_is_load      (MEM_is_load),
    .MEM_is_store     (MEM_is_store),
    .MEM_funct3       (MEM_funct3),
    .MEM_alu_out      (MEM_alu_out),
    .MEM_rs2          (MEM_rs2),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .MEM_rdata        (MEM_rdata),
    .mem_stall        (mem_stall),
    .misaligned       (misaligned),
    .dmem_err         (dmem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    int          kind;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = '0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata, input int delay,
                              input int kind, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_be,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.valid = valid; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
    v.rdata = rdata; v.delay = delay; v.kind = kind; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_be = e_be; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference: access width in bytes, alignment by modulo, lane replication and extension
  // computed arithmetically from the instruction alone.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    vec_t   r;
    int     w;
    int     off;
    logic   ldm, stm, legal;
    longint val;
    r   = v;
    ldm = v.ld;
    stm = v.st && !v.ld;
    w   = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(v.addr % 4);
    legal = ldm ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 inside {3'd0, 3'd1, 3'd2});
    r.e_rdata = prev;
    r.e_addr  = v.addr - (v.addr % 4);
    r.e_wdata = '0;
    r.e_be    = 4'hF;
    if (!(v.valid && (ldm || stm))) begin
      r.kind = KIdle;
    end else if (!legal || (off % w) != 0) begin
      r.kind = KBad;
    end else begin
      r.kind = KGood;
      if (stm) begin
        r.e_be = 4'(((1 << w) - 1) << off);
        for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.rs2[8*(i % w) +: 8];
      end else begin
        val = longint'({32'b0, v.rdata >> (8 * off)}) % (longint'(1) << (8 * w));
        if (!v.f3[2] && w < 4 && val >= (longint'(1) << (8 * w - 1)))
          val = val - (longint'(1) << (8 * w));
        r.e_rdata = 32'(val);
      end
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic exp_rd, exp_wr;
    exp_rd = (v.kind == KGood) && v.ld;
    exp_wr = (v.kind == KGood) && v.st && !v.ld;
    MEM_valid = v.valid; MEM_is_load = v.ld; MEM_is_store = v.st;
    MEM_funct3 = v.f3; MEM_alu_out = v.addr; MEM_rs2 = v.rs2;
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    #1;
    chk({tag, ".stall_issue"}, 32'(mem_stall), 32'(v.kind == KGood));
    chk({tag, ".no_req_idle"}, 32'({dmem_read, dmem_write}), 32'(0));
    @(negedge clk);
    if (v.kind == KGood) begin
      for (int c = 1; c <= v.delay; c++) begin
        dmem_resp  = (c == v.delay);
        dmem_rdata = (c == v.delay) ? v.rdata : $urandom;
        #1;
        chk({tag, ".busy_stall"}, 32'(mem_stall), 32'(1));
        chk({tag, ".busy_read"}, 32'(dmem_read), 32'(exp_rd));
        chk({tag, ".busy_write"}, 32'(dmem_write), 32'(exp_wr));
        chk({tag, ".busy_addr"}, dmem_address, v.e_addr);
        chk({tag, ".busy_be"}, 32'(dmem_byte_enable), 32'(v.e_be));
        if (exp_wr) chk({tag, ".busy_wdata"}, dmem_wdata, v.e_wdata);
        @(negedge clk);
      end
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      chk({tag, ".done_stall"}, 32'(mem_stall), 32'(0));
      chk({tag, ".done_req"}, 32'({dmem_read, dmem_write}), 32'(0));
      chk({tag, ".done_rdata"}, MEM_rdata, v.e_rdata);
      chk({tag, ".done_err"}, 32'(dmem_err), 32'(0));
      @(negedge clk);
    end
    MEM_valid = 1'b0; MEM_is_load = 1'b0; MEM_is_store = 1'b0;
    dmem_resp  = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    #1;
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(v.kind == KBad));
    chk({tag, ".after_stall"}, 32'(mem_stall), 32'(0));
    chk({tag, ".after_req"}, 32'({dmem_read, dmem_write}), 32'(0));
    chk({tag, ".after_rdata"}, MEM_rdata, v.e_rdata);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk({tag, ".misaligned_pulse"}, 32'(misaligned), 32'(0));
    chk({tag, ".stray_rdata"}, MEM_rdata, v.e_rdata);
    model_rdata = v.e_rdata;
  endtask

  initial begin
    logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    vec_t v;

    tbl.push_back(mk(1, 1, 0, 3'b000, 32'h1003, 0, 32'h80AABBCC, 3, KGood, 32'h1000, 0, 4'hF,
                     32'hFFFFFF80));
    tbl.push_back(mk(1, 1, 0, 3'b101, 32'h2002, 0, 32'hBEEF1234, 1, KGood, 32'h2000, 0, 4'hF,
                     32'h0000BEEF));
    tbl.push_back(mk(1, 0, 1, 3'b000, 32'h3001, 32'h123456A5, 0, 1, KGood, 32'h3000,
                     32'hA5A5A5A5, 4'b0010, 32'h0000BEEF));
    tbl.push_back(mk(1, 1, 0, 3'b010, 32'h4002, 0, 32'h11111111, 1, KBad, 0, 0, 4'hF,
                     32'h0000BEEF));
    tbl.push_back(mk(1, 1, 0, 3'b001, 32'h5000, 0, 32'h00008001, 2, KGood, 32'h5000, 0, 4'hF,
                     32'hFFFF8001));
    tbl.push_back(mk(1, 0, 1, 3'b001, 32'h6002, 32'hDEADBEEF, 0, 2, KGood, 32'h6000,
                     32'hBEEFBEEF, 4'b1100, 32'hFFFF8001));
    tbl.push_back(mk(1, 0, 1, 3'b010, 32'h7004, 32'hCAFEF00D, 0, 1, KGood, 32'h7004,
                     32'hCAFEF00D, 4'hF, 32'hFFFF8001));
    tbl.push_back(mk(1, 1, 0, 3'b100, 32'h8002, 0, 32'h12345678, 1, KGood, 32'h8000, 0, 4'hF,
                     32'h00000034));
    tbl.push_back(mk(1, 1, 0, 3'b010, 32'h9000, 0, 32'h87654321, 4, KGood, 32'h9000, 0, 4'hF,
                     32'h87654321));
    tbl.push_back(mk(1, 0, 1, 3'b001, 32'hA001, 32'h5555, 0, 1, KBad, 0, 0, 4'hF, 32'h87654321));
    tbl.push_back(mk(1, 1, 0, 3'b011, 32'hB000, 0, 0, 1, KBad, 0, 0, 4'hF, 32'h87654321));
    tbl.push_back(mk(1, 0, 1, 3'b100, 32'hC000, 32'h1, 0, 1, KBad, 0, 0, 4'hF, 32'h87654321));
    tbl.push_back(mk(1, 1, 1, 3'b000, 32'hD001, 32'hFFFFFFFF, 32'h00007F00, 2, KGood, 32'hD000,
                     0, 4'hF, 32'h0000007F));
    tbl.push_back(mk(0, 1, 0, 3'b010, 32'hE000, 0, 32'hFFFFFFFF, 1, KIdle, 0, 0, 4'hF,
                     32'h0000007F));
    tbl.push_back(mk(1, 0, 0, 3'b010, 32'hE004, 0, 32'hFFFFFFFF, 1, KIdle, 0, 0, 4'hF,
                     32'h0000007F));
    tbl.push_back(mk(1, 1, 0, 3'b000, 32'hF000, 0, 32'h8000007E, 1, KGood, 32'hF000, 0, 4'hF,
                     32'h0000007E));
    tbl.push_back(mk(1, 1, 0, 3'b001, 32'hF002, 0, 32'hC0DE0000, 3, KGood, 32'hF000, 0, 4'hF,
                     32'hFFFFC0DE));

    reset = 1'b1; MEM_valid = 1'b0; MEM_is_load = 1'b0; MEM_is_store = 1'b0;
    MEM_funct3 = '0; MEM_alu_out = '0; MEM_rs2 = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.read", 32'(dmem_read), 32'(0));
    chk("reset.write", 32'(dmem_write), 32'(0));
    chk("reset.address", dmem_address, 32'(0));
    chk("reset.wdata", dmem_wdata, 32'(0));
    chk("reset.be", 32'(dmem_byte_enable), 32'(0));
    chk("reset.rdata", MEM_rdata, 32'(0));
    chk("reset.misaligned", 32'(misaligned), 32'(0));
    chk("reset.err", 32'(dmem_err), 32'(0));
    chk("reset.stall", 32'(mem_stall), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset two cycles into BUSY, then a stray response.
    MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_is_store = 1'b0;
    MEM_funct3 = 3'b010; MEM_alu_out = 32'h100; dmem_resp = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy.read", 32'(dmem_read), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MEM_valid = 1'b0; MEM_is_load = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("rstbusy.req", 32'({dmem_read, dmem_write}), 32'(0));
    chk("rstbusy.stall", 32'(mem_stall), 32'(0));
    chk("rstbusy.rdata", MEM_rdata, 32'(0));
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("rstbusy.stray_rdata", MEM_rdata, 32'(0));
    chk("rstbusy.stray_req", 32'({dmem_read, dmem_write}), 32'(0));
    model_rdata = '0;
    run_txn(tbl[0], "rstbusy.reissue");

`ifdef LSU_TIMEOUT_EN
    MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_is_store = 1'b0;
    MEM_funct3 = 3'b010; MEM_alu_out = 32'h200; dmem_resp = 1'b0;
    #1;
    chk("tmo.stall_issue", 32'(mem_stall), 32'(1));
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("tmo.busy_read", 32'(dmem_read), 32'(1));
      chk("tmo.busy_stall", 32'(mem_stall), 32'(1));
      chk("tmo.busy_err", 32'(dmem_err), 32'(0));
      @(negedge clk);
    end
    #1;
    chk("tmo.err", 32'(dmem_err), 32'(1));
    chk("tmo.read_drop", 32'(dmem_read), 32'(0));
    chk("tmo.done_stall", 32'(mem_stall), 32'(0));
    chk("tmo.rdata", MEM_rdata, model_rdata);
    @(negedge clk);
    MEM_valid = 1'b0; MEM_is_load = 1'b0;
    #1;
    chk("tmo.err_pulse", 32'(dmem_err), 32'(0));
    chk("tmo.idle_stall", 32'(mem_stall), 32'(0));
`else
    MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_is_store = 1'b0;
    MEM_funct3 = 3'b010; MEM_alu_out = 32'h300; dmem_resp = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      #1;
      chk("wait.busy_read", 32'(dmem_read), 32'(1));
      chk("wait.busy_stall", 32'(mem_stall), 32'(1));
      chk("wait.err", 32'(dmem_err), 32'(0));
      @(negedge clk);
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("wait.done_stall", 32'(mem_stall), 32'(0));
    chk("wait.rdata", MEM_rdata, 32'h0BADF00D);
    model_rdata = 32'h0BADF00D;
    @(negedge clk);
    MEM_valid = 1'b0; MEM_is_load = 1'b0;
`endif

    for (int n = 0; n < 200; n++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.ld    = 1'($urandom_range(0, 1));
      v.st    = 1'($urandom_range(0, 1));
      v.f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : lf3[$urandom_range(0, 4)];
      v.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.rs2   = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(1, 4);
      v = model(v, model_rdata);
      run_txn(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit of the MEM stage; sits directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM-registered address, store data and funct3. Drives the data-cache request/response handshake and stalls the pipeline until the access completes.
- Produces the sign- or zero-extended load value (MEM_rdata) that the MEM/WB register latches on the cycle the stall drops.

Parameters:
TIMEOUT_CYCLES, 64, BUSY-state cycle limit before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
MEM_valid  input  1  MEM stage holds a valid instruction
MEM_is_load  input  1  instruction is a load
MEM_is_store  input  1  instruction is a store
MEM_funct3  input  3  RV32I load/store width code
MEM_alu_out  input  32  effective byte address
MEM_rs2  input  32  store source data
dmem_read  output  1  cache read request (registered)
dmem_write  output  1  cache write request (registered)
dmem_address  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_byte_enable  output  4  active byte lanes
dmem_rdata  input  32  cache read data, valid with dmem_resp
dmem_resp  input  1  one-cycle completion pulse
MEM_rdata  output  32  extended load result, held until the next load completes
mem_stall  output  1  freeze PC and all pipe registers
misaligned  output  1  one-cycle pulse on an illegal or misaligned access
dmem_err  output  1  timeout abort pulse (LSU_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset values:
  - State is IDLE.
  - dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, MEM_rdata, misaligned and dmem_err are all 0.
- Definitions:
  - op = MEM_valid & (MEM_is_load | MEM_is_store).
  - bad = funct3 not in {000,001,010,100,101} for loads, not in {000,001,010} for stores, or half access with addr[0]=1, or word access with addr[1:0]!=0.
- IDLE, op & !bad:
  - Latch address, wdata and byte_enable.
  - Set dmem_read or dmem_write next edge; go to BUSY.
  - mem_stall=1 this cycle (combinational).
- IDLE, op & bad:
  - No request is issued.
  - misaligned=1 for the next cycle; MEM_rdata is unchanged.
  - mem_stall=0.
- BUSY:
  - Requests and latched fields are held stable; mem_stall=1.
  - On dmem_resp: clear the request at the next edge. For loads, register the extended data into MEM_rdata. Go to DONE.
- DONE:
  - mem_stall=0 for exactly one cycle, so the pipeline advances.
  - No new request is issued even though the same instruction is still present. Go to IDLE.
- Latency: a cache hit with resp in the first BUSY cycle gives 2 stall cycles plus the DONE cycle.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, be=4'b1111.
- Load extract: the byte or half is selected by addr[1:0] from dmem_rdata.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: passed through unchanged.
- Loads drive be=4'b1111.
- dmem_resp in IDLE or DONE is ignored.
- MEM_is_load & MEM_is_store both set: treated as load.
- Reset mid-BUSY: requests drop at that edge and state returns to IDLE. A late dmem_resp after that is ignored.
- MEM_valid=0: no activity, mem_stall=0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without dmem_resp: drop the request, pulse dmem_err for 1 cycle, leave MEM_rdata unchanged and go to DONE.
- Undefined: no counter; BUSY waits indefinitely; dmem_err is tied 0.

Test Plan:
- LB at addr 0x1003, resp with rdata 0x80AA_BBCC after 3 cycles -> dmem_address=0x1000, MEM_rdata=0xFFFF_FF80, mem_stall high for 4 cycles then low for 1.
- LHU at addr 0x2002, rdata 0xBEEF_1234 -> MEM_rdata=0x0000_BEEF, be=4'b1111.
- SB at addr 0x3001, rs2=0x1234_56A5 -> dmem_write=1, wdata=0xA5A5_A5A5, be=4'b0010; after resp no second write during DONE.
- LW at addr 0x4002 -> no dmem_read, misaligned pulse 1 cycle, mem_stall=0, MEM_rdata unchanged.
- Assert reset 2 cycles into BUSY, then give a stray resp -> requests 0 after the reset edge, state IDLE, MEM_rdata=0, stray resp ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no resp -> dmem_err pulse after 4 BUSY cycles, dmem_read drops, one DONE cycle with mem_stall=0.
